// File: rtl/star_row_scroller_if.sv
// star_row_scroller_if
// Bundles the two buses the starfield sequencer drives: the control side of
// the single-port star table RAM and the valid/ready star record stream
// towards the plotter.
//   ram_rden/ram_wren   RAM read / write enables (never both high)
//   ram_address         9-bit row address
//   ram_data            18-bit write data {x, speed, color}
//   ram_q               18-bit read data, valid 2 cycles after ram_rden
//   star_valid/ready    record handshake
//   star_x/y/color      record payload (pre-scroll x, row, colour)
// master = sequencer side, slave = RAM + plotter side.
interface star_row_scroller_if;
  logic        ram_rden;
  logic        ram_wren;
  logic [8:0]  ram_address;
  logic [17:0] ram_data;
  logic [17:0] ram_q;
  logic        star_valid;
  logic        star_ready;
  logic [8:0]  star_x;
  logic [8:0]  star_y;
  logic [5:0]  star_color;

  modport master (
    output ram_rden, ram_wren, ram_address, ram_data,
    output star_valid, star_x, star_y, star_color,
    input  ram_q, star_ready
  );

  modport slave (
    input  ram_rden, ram_wren, ram_address, ram_data,
    input  star_valid, star_x, star_y, star_color,
    output ram_q, star_ready
  );
endinterface

// File: rtl/star_row_scroller.sv
// star_row_scroller
// On every frame_start walks the star table (one entry per scanline), reads
// each entry, writes back its scrolled x position and offers the pre-scroll
// record downstream. Read and write-back share the RAM's single address port,
// so each row is handled strictly in sequence RD, WAIT, CAP, WR, OUT.
// Ports:
//   clock        sole clock (RAM shares it)
//   reset        asynchronous, active-high
//   frame_start  1-cycle pulse that starts a walk
//   scroll_en    1: x -= speed on write-back, 0: x written back unchanged
//   busy         walk in progress
//   done         1-cycle pulse in the first idle cycle after the last record
//   overrun      1-cycle pulse when frame_start arrives during a walk
//   bus          RAM control + star record stream (master modport)
module star_row_scroller #(
  parameter int STAR_COUNT = 512
) (
  input  logic clock,
  input  logic reset,
  input  logic frame_start,
  input  logic scroll_en,
  output logic busy,
  output logic done,
  output logic overrun,
  star_row_scroller_if.master bus
);

  localparam logic [8:0] LAST_ROW = 9'(STAR_COUNT - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WAIT,
    CAP,
    WR,
    OUT
  } state_t;

  state_t      state;
  logic [8:0]  row;
  logic [8:0]  x_q;
  logic [5:0]  color_q;
  logic [8:0]  scrolled_x;

  // The write-back word is formed on the same edge that captures ram_q, so the
  // scroll arithmetic works straight off the RAM output; 9-bit wrap is free.
  always_comb begin
    scrolled_x = bus.ram_q[17:9] - 9'(bus.ram_q[8:6]);
  end

  // Single sequencer process. Every output is a flop; RAM strobes default low
  // each cycle and are raised only on the edge entering their own state, which
  // keeps address/data at zero whenever no access is taking place.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      row             <= '0;
      x_q             <= '0;
      color_q         <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      overrun         <= 1'b0;
      bus.ram_rden    <= 1'b0;
      bus.ram_wren    <= 1'b0;
      bus.ram_address <= '0;
      bus.ram_data    <= '0;
      bus.star_valid  <= 1'b0;
      bus.star_x      <= '0;
      bus.star_y      <= '0;
      bus.star_color  <= '0;
    end else begin
      bus.ram_rden    <= 1'b0;
      bus.ram_wren    <= 1'b0;
      bus.ram_address <= '0;
      bus.ram_data    <= '0;
      done            <= 1'b0;
      overrun         <= frame_start && (state != IDLE);

      case (state)
        IDLE: begin
          if (frame_start) begin
            state           <= RD;
            row             <= '0;
            busy            <= 1'b1;
            bus.ram_rden    <= 1'b1;
            bus.ram_address <= '0;
          end
        end

        RD: state <= WAIT;

        WAIT: state <= CAP;

        CAP: begin
          x_q             <= bus.ram_q[17:9];
          color_q         <= bus.ram_q[5:0];
          bus.ram_wren    <= 1'b1;
          bus.ram_address <= row;
          bus.ram_data    <= {(scroll_en ? scrolled_x : bus.ram_q[17:9]),
                              bus.ram_q[8:0]};
          state           <= WR;
        end

        WR: begin
          bus.star_valid <= 1'b1;
          bus.star_x     <= x_q;
          bus.star_y     <= row;
          bus.star_color <= color_q;
          state          <= OUT;
        end

        OUT: begin
          // Without star_ready the record simply holds; nothing else moves.
          if (bus.star_ready) begin
            bus.star_valid <= 1'b0;
            bus.star_x     <= '0;
            bus.star_y     <= '0;
            bus.star_color <= '0;
            if (row == LAST_ROW) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              row             <= row + 9'd1;
              bus.ram_rden    <= 1'b1;
              bus.ram_address <= row + 9'd1;
              state           <= RD;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_star_row_scroller.sv
// tb_star_row_scroller
// Randomised bench for star_row_scroller with a behavioural star table RAM.
// Expected records are queued when a walk starts; a negedge monitor pops and
// compares every accepted record and checks bus hygiene each cycle.
module tb_star_row_scroller;
  localparam int STAR_COUNT = 512;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic frame_start = 1'b0;
  logic scroll_en = 1'b0;
  logic busy, done, overrun;

  star_row_scroller_if bus();

  star_row_scroller #(.STAR_COUNT(STAR_COUNT)) dut (
    .clock       (clock),
    .reset       (reset),
    .frame_start (frame_start),
    .scroll_en   (scroll_en),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun),
    .bus         (bus)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Star table RAM: single port, 2-cycle read latency, q holds between reads.
  logic [17:0] ram_mem[STAR_COUNT];
  logic [17:0] init_img[STAR_COUNT];
  logic        load_ram = 1'b0;
  logic [17:0] rd_pipe;

  always @(posedge clock) begin
    if (load_ram) begin
      for (int i = 0; i < STAR_COUNT; i++) ram_mem[i] <= init_img[i];
    end else if (bus.ram_wren) begin
      ram_mem[bus.ram_address] <= bus.ram_data;
    end
    if (bus.ram_rden) rd_pipe <= ram_mem[bus.ram_address];
    bus.ram_q <= rd_pipe;
  end

  // Downstream ready: forced low, random, or always high.
  logic hold_low = 1'b0;
  logic rand_ready = 1'b0;

  always @(posedge clock) begin
    #1;
    if (hold_low)        bus.star_ready = 1'b0;
    else if (rand_ready) bus.star_ready = ($urandom_range(0, 3) != 0);
    else                 bus.star_ready = 1'b1;
  end

  // Reference model: table image plus the image the current walk will leave.
  logic [17:0] model_mem[STAR_COUNT];
  logic [17:0] pending_mem[STAR_COUNT];
  logic [23:0] exp_q[$];

  task automatic start_walk(input logic se);
    for (int i = 0; i < STAR_COUNT; i++) begin
      int x  = int'(model_mem[i][17:9]);
      int sp = int'(model_mem[i][8:6]);
      int nx = se ? (x - sp + 512) % 512 : x;
      exp_q.push_back({9'(x), 9'(i), model_mem[i][5:0]});
      pending_mem[i] = {9'(nx), model_mem[i][8:0]};
    end
  endtask

  task automatic commit_rows(input int n);
    for (int i = 0; i < n; i++) model_mem[i] = pending_mem[i];
  endtask

  task automatic compare_ram(input string tag);
    for (int i = 0; i < STAR_COUNT; i++) check(tag, ram_mem[i], model_mem[i]);
  endtask

  // Monitor
  logic        prev_stall = 1'b0;
  logic [23:0] prev_rec = '0;
  logic [23:0] cur_rec;
  logic [23:0] exp_rec;
  int          done_count = 0;
  int          overrun_count = 0;
  int          last_y = -1;

  always @(negedge clock) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      cur_rec = {bus.star_x, bus.star_y, bus.star_color};
      check("rden_wren_exclusive", {31'd0, bus.ram_rden & bus.ram_wren}, 0);
      if (!bus.ram_rden && !bus.ram_wren) check("addr_idle_zero", bus.ram_address, 0);
      if (!bus.ram_wren) check("data_idle_zero", bus.ram_data, 0);
      if (!bus.star_valid) check("star_idle_zero", cur_rec, 0);
      if (prev_stall) check("star_stable", {bus.star_valid, cur_rec}, {1'b1, prev_rec});
      if (bus.star_valid && bus.star_ready) begin
        if (exp_q.size() == 0) begin
          check("record_expected", 0, 1);
        end else begin
          exp_rec = exp_q.pop_front();
          check("star_record", cur_rec, exp_rec);
        end
        last_y = int'(bus.star_y);
      end
      prev_stall = bus.star_valid && !bus.star_ready;
      prev_rec   = cur_rec;
      if (done) done_count++;
      if (overrun) overrun_count++;
    end
  end

  task automatic raise_frame(input logic se, input bit push);
    @(posedge clock);
    #1;
    scroll_en   = se;
    frame_start = 1'b1;
    if (push) start_walk(se);
  endtask

  task automatic lower_frame();
    @(posedge clock);
    #1;
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    bit ok = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clock);
      if (done) begin
        ok = 1;
        break;
      end
    end
    check(name, {31'd0, ok}, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy_pulses"}, {busy, done, overrun}, 0);
    check({tag, "_ram_ctrl"}, {bus.ram_rden, bus.ram_wren, bus.ram_address, bus.ram_data}, 0);
    check({tag, "_star"}, {bus.star_valid, bus.star_x, bus.star_y, bus.star_color}, 0);
  endtask

  initial begin
    int first_rd, first_valid, done_idx, ov0, dn0;
    bit found;
    logic [23:0] rec;

    for (int i = 0; i < STAR_COUNT; i++) init_img[i] = 18'($urandom);
    init_img[0] = {9'd5, 3'd3, 6'h2A};
    init_img[1] = {9'd1, 3'd3, 6'h15};
    for (int i = 0; i < STAR_COUNT; i++) model_mem[i] = init_img[i];
    load_ram = 1'b1;
    repeat (2) @(posedge clock);
    #1 load_ram = 1'b0;

    @(negedge clock);
    check_all_zero("reset");
    @(negedge clock);
    reset = 1'b0;

    // Walk 1: scroll, ready always high, latency and full-walk timing.
    $display("[TB] walk 1: scroll, timing");
    rand_ready = 1'b0;
    repeat (2) @(posedge clock);
    raise_frame(1'b1, 1'b1);
    first_rd = -1; first_valid = -1; done_idx = -1;
    for (int idx = 0; idx < 3000; idx++) begin
      @(negedge clock);
      if (bus.ram_rden && first_rd < 0) first_rd = idx;
      if (bus.star_valid && first_valid < 0) begin
        first_valid = idx;
        check("w1_first_x", bus.star_x, 5);
        check("w1_first_y", bus.star_y, 0);
        check("w1_first_color", bus.star_color, 6'h2A);
      end
      if (done) begin
        done_idx = idx;
        break;
      end
      if (idx == 0) lower_frame();
    end
    check("w1_first_rden_cycle", first_rd, 1);
    check("w1_first_valid_cycle", first_valid, 5);
    check("w1_done_cycle", done_idx, 2561);
    commit_rows(STAR_COUNT);
    check("w1_queue_empty", exp_q.size(), 0);
    check("w1_ram0_x", ram_mem[0][17:9], 9'd2);
    check("w1_ram1_wrap_x", ram_mem[1][17:9], 9'h1FE);
    compare_ram("w1_ram");

    // Walk 2: no scroll, backpressure on row 7, overrun at row 100.
    $display("[TB] walk 2: backpressure and overrun");
    @(posedge clock);
    ov0 = overrun_count; dn0 = done_count;
    raise_frame(1'b0, 1'b1);
    lower_frame();
    found = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clock);
      if (bus.ram_rden && bus.ram_address == 9'd7) begin found = 1; break; end
    end
    check("w2_row7_rd_seen", {31'd0, found}, 1);
    hold_low = 1'b1;
    found = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      if (bus.star_valid && bus.star_y == 9'd7) begin found = 1; break; end
    end
    check("w2_row7_out_seen", {31'd0, found}, 1);
    rec = {bus.star_x, bus.star_y, bus.star_color};
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clock);
      check("bp_ram_quiet", {bus.ram_rden, bus.ram_wren}, 0);
      check("bp_star_hold", {bus.star_valid, bus.star_x, bus.star_y, bus.star_color}, {1'b1, rec});
    end
    hold_low = 1'b0;
    @(negedge clock);
    check("bp_handshake", {bus.star_valid, bus.star_ready}, 2'b11);
    @(negedge clock);
    check("bp_row8_rd", {bus.ram_rden, bus.ram_address}, {1'b1, 9'd8});
    found = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clock);
      if (bus.star_valid && bus.star_y == 9'd100) begin found = 1; break; end
    end
    check("w2_row100_seen", {31'd0, found}, 1);
    raise_frame(1'b0, 1'b0);
    lower_frame();
    wait_done(3000, "w2_done_seen");
    repeat (5) @(posedge clock);
    check("w2_overrun_pulses", overrun_count - ov0, 1);
    check("w2_done_pulses", done_count - dn0, 1);
    check("w2_last_row", last_y, 511);
    check("w2_queue_empty", exp_q.size(), 0);
    commit_rows(STAR_COUNT);
    compare_ram("w2_ram");

    // Walk 3: random ready; restart in the done cycle without overrun.
    $display("[TB] walk 3: random ready, back-to-back restart");
    rand_ready = 1'b1;
    @(posedge clock);
    ov0 = overrun_count;
    raise_frame(1'b1, 1'b1);
    lower_frame();
    found = 0;
    for (int k = 0; k < 6000; k++) begin
      @(negedge clock);
      if (bus.star_valid && bus.star_ready && bus.star_y == 9'd511) begin found = 1; break; end
    end
    check("w3_last_accept_seen", {31'd0, found}, 1);
    commit_rows(STAR_COUNT);
    compare_ram("w3_ram");
    raise_frame(1'b1, 1'b1);
    @(negedge clock);
    check("w3_done_with_restart", {done, busy}, 2'b10);
    lower_frame();
    @(negedge clock);
    check("w4_restart_rd", {bus.ram_rden, bus.ram_address}, {1'b1, 9'd0});

    // Walk 4: reset during the WAIT cycle of row 50.
    $display("[TB] walk 4: reset mid-walk");
    found = 0;
    for (int k = 0; k < 6000; k++) begin
      @(negedge clock);
      if (bus.ram_rden && bus.ram_address == 9'd50) begin found = 1; break; end
    end
    check("w4_row50_rd_seen", {31'd0, found}, 1);
    @(posedge clock);
    #2 reset = 1'b1;
    #1 check_all_zero("midwalk_reset");
    exp_q.delete();
    commit_rows(50);
    check("w3_w4_no_overrun", overrun_count - ov0, 0);
    repeat (3) @(negedge clock);
    #2 reset = 1'b0;
    repeat (4) @(posedge clock);
    check("ram50_unwritten", ram_mem[50], model_mem[50]);
    check("ram49_written", ram_mem[49], model_mem[49]);
    compare_ram("w4_ram");

    // Walk 5: fresh walk after reset starts from row 0.
    $display("[TB] walk 5: restart after reset");
    @(posedge clock);
    dn0 = done_count;
    raise_frame(1'b1, 1'b1);
    lower_frame();
    found = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      if (bus.star_valid) begin found = 1; break; end
    end
    check("w5_first_valid_seen", {31'd0, found}, 1);
    check("w5_first_row", bus.star_y, 0);
    wait_done(6000, "w5_done_seen");
    repeat (3) @(posedge clock);
    check("w5_done_pulses", done_count - dn0, 1);
    check("w5_queue_empty", exp_q.size(), 0);
    commit_rows(STAR_COUNT);
    compare_ram("w5_ram");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
